sim_exit_ctrl: RTL and testbench
================================

// Module: sim_exit_ctrl
// PURPOSE
// - Memory-mapped simulation-exit controller inside the testharness. Drives exit_valid_o/exit_value_o
//   into the top-level bench, which prints EXIT SUCCESS/FAILURE and calls $finish.
// - Software writes its return code. The block waits a drain period so UART/stdout traffic flushes,
//   then asserts exit.
// - A programmable cycle watchdog forces a failure exit when software hangs.
// PARAMETERS
// - DRAIN_CYCLES    16            cycles between exit trigger and exit_valid_o; 0 = exit next cycle
// - WDOG_EXIT_CODE  32'hDEAD0001  exit_value_o reported on watchdog expiry
// PORTS
// - clk_i           in   1   clock
// - rst_i           in   1   reset, asynchronous, active-high
// - req_i           in   1   OBI request
// - gnt_o           out  1   OBI grant; combinational, = req_i
// - addr_i          in   32  byte address; only bits [4:2] decoded
// - we_i            in   1   write enable
// - be_i            in   4   byte enables
// - wdata_i         in   32  write data
// - rvalid_o        out  1   response valid, one cycle after each granted request (read or write)
// - rdata_o         out  32  read data, valid with rvalid_o; 0 for writes
// - exit_valid_o    out  1   exit requested; held high until reset
// - exit_value_o    out  32  exit code; 0 = success
// - wdog_expired_o  out  1   sticky; set when the watchdog caused the exit
// BEHAVIOUR
// - Reset values (async, rst_i=1): all outputs 0; state RUN; wdog_limit=0, wdog_cnt=0, drain_cnt=0.
// - Register map (word offsets):
//   - 0x00 EXIT_VALUE  WO: any write with be_i!=0 latches the be-masked wdata as exit code. Triggers exit.
//   - 0x04 WDOG_LIMIT  RW: be-honoured. 0 = watchdog off. Any write also clears wdog_cnt.
//   - 0x08 WDOG_KICK   WO: any write clears wdog_cnt.
//   - 0x0C STATUS      RO: {28'b0, wdog_expired, exit_valid, state[1:0]} (RUN=0, DRAIN=1, EXIT=2).
//   - Unmapped offsets: reads return 0, writes ignored. Writes to RO registers are ignored.
// - Bus: gnt_o=req_i; rvalid_o registered one cycle after req_i&gnt_o; back-to-back requests every
//   cycle supported.
// - FSM:
//   - RUN: if wdog_limit!=0, wdog_cnt increments each cycle. Expiry when wdog_cnt==wdog_limit-1,
//     i.e. the limit-th cycle after the last clear.
//     - On EXIT_VALUE write: latch code, load drain_cnt=DRAIN_CYCLES, go to DRAIN (or EXIT if 0).
//     - On expiry: latch WDOG_EXIT_CODE, set wdog_expired_o, same transition.
//   - DRAIN: wdog frozen. drain_cnt decrements; when drain_cnt==1, go to EXIT next edge.
//     Further EXIT_VALUE writes are ignored; first code wins.
//   - EXIT: exit_valid_o=1, exit_value_o=latched code. Terminal until reset. Bus still responds.
// - Latency: exit_valid_o rises exactly DRAIN_CYCLES+1 cycles after the triggering write is granted.
// - Simultaneous events:
//   - EXIT_VALUE write and expiry in the same cycle: write wins; wdog_expired_o stays 0.
//   - KICK or LIMIT write and expiry in the same cycle: clear wins; no expiry.
// - wdog_cnt is 32-bit and saturates; it cannot wrap because expiry occurs first.
// - rst_i asserted mid-DRAIN or in EXIT: immediate return to reset values; the pending exit is lost.
// - exit_value_o is stable while exit_valid_o=1.
// CONFIGURATION
// - Macro SIM_EXIT_CYCLE_COUNT_EN.
// - Defined: 64-bit free-running cycle counter, cleared by reset, freezes on entry to EXIT.
//   - Readable at 0x10 (low word) and 0x14 (high word).
//   - Reading 0x10 snapshots the high word; a following read of 0x14 returns the snapshot (coherent pair).
// - Undefined: no counter logic; 0x10/0x14 behave as unmapped (read 0).
// TESTING
// - DRAIN_CYCLES=16; write 0x00=0 at cycle T -> exit_valid_o=1 at T+17, exit_value_o=0, wdog_expired_o=0.
// - Write 0x00=5, then 0x00=9 during DRAIN -> exit_value_o=5; STATUS read in DRAIN returns 0x1.
// - Write 0x04=100, no kicks -> exit_value_o=0xDEAD0001 and wdog_expired_o=1, 100+DRAIN_CYCLES+1
//   cycles after the write.
// - Write 0x04=100, kick 0x08 every 50 cycles for 1000 cycles -> no exit.
//   Then 0x00=3 and expiry in the same cycle -> exit code 3, wdog_expired_o=0.
// - Assert rst_i mid-DRAIN -> all outputs 0 immediately; STATUS reads 0; a new write 0x00=7 exits with 7.
// - With SIM_EXIT_CYCLE_COUNT_EN: read 0x10 then 0x14 across a 2^32 boundary -> coherent 64-bit value.
//   Without the macro: both reads return 0.

Source files
------------

// File: rtl/sim_exit_ctrl.sv
// Simulation-exit controller: latches a software return code, drains for DRAIN_CYCLES, then raises exit.
// Optional 64-bit cycle counter at 0x10/0x14 is built when SIM_EXIT_CYCLE_COUNT_EN is defined.
module sim_exit_ctrl #(
    parameter int unsigned DRAIN_CYCLES   = 16,
    parameter logic [31:0] WDOG_EXIT_CODE = 32'hDEAD0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        wdog_expired_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXIT  = 2'd2
    } state_t;

    localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_drain_cnt, w_drain_nxt;
    logic [31:0] r_code, w_code_nxt;
    logic        r_expired;
    logic        w_latch_code, w_set_expired;
    logic [31:0] r_wdog_limit, r_wdog_cnt;
    logic        r_rvalid;
    logic [31:0] r_rdata, w_rdata;

    logic [2:0]  w_idx;
    logic [31:0] w_be_mask;
    logic        w_wr, w_rd, w_wr_exit, w_wr_limit, w_wr_kick, w_wdog_clr, w_expire;
    logic        w_unused;

    assign w_idx      = addr_i[4:2];
    assign w_be_mask  = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign w_wr       = req_i & we_i;
    assign w_rd       = req_i & ~we_i;
    assign w_wr_exit  = w_wr & (w_idx == 3'd0) & (|be_i);
    assign w_wr_limit = w_wr & (w_idx == 3'd1);
    assign w_wr_kick  = w_wr & (w_idx == 3'd2);
    assign w_wdog_clr = w_wr_limit | w_wr_kick;
    assign w_unused   = ^{addr_i[31:5], addr_i[1:0]};

    // A clearing write or an exit write in the expiry cycle pre-empts the watchdog.
    assign w_expire = (r_state == ST_RUN) && (r_wdog_limit != 32'd0) &&
                      (r_wdog_cnt == r_wdog_limit - 32'd1) && !w_wdog_clr && !w_wr_exit;

    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_code_nxt    = r_code;
        w_latch_code  = 1'b0;
        w_set_expired = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_wr_exit || w_expire) begin
                    w_latch_code  = 1'b1;
                    w_code_nxt    = w_wr_exit ? (wdata_i & w_be_mask) : WDOG_EXIT_CODE;
                    w_set_expired = !w_wr_exit;
                    if (DRAIN_LOAD == 32'd0) begin
                        w_state_nxt = ST_EXIT;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                w_drain_nxt = r_drain_cnt - 32'd1;
                if (r_drain_cnt == 32'd1) begin
                    w_state_nxt = ST_EXIT;
                end
            end
            ST_EXIT: begin
                w_state_nxt = ST_EXIT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 32'd0;
            r_code      <= 32'd0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (w_latch_code) begin
                r_code <= w_code_nxt;
            end
            if (w_set_expired) begin
                r_expired <= 1'b1;
            end
        end
    end

    // Watchdog counts only in RUN; saturating so it can never wrap past the limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog_limit <= 32'd0;
            r_wdog_cnt   <= 32'd0;
        end else begin
            if (w_wr_limit) begin
                r_wdog_limit <= (r_wdog_limit & ~w_be_mask) | (wdata_i & w_be_mask);
            end
            if (w_wdog_clr) begin
                r_wdog_cnt <= 32'd0;
            end else if ((r_state == ST_RUN) && (r_wdog_limit != 32'd0) &&
                         (r_wdog_cnt != 32'hFFFF_FFFF)) begin
                r_wdog_cnt <= r_wdog_cnt + 32'd1;
            end
        end
    end

`ifdef SIM_EXIT_CYCLE_COUNT_EN
    logic [63:0] r_cyc;
    logic [31:0] r_cyc_hi_snap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cyc         <= 64'd0;
            r_cyc_hi_snap <= 32'd0;
        end else begin
            if (r_state != ST_EXIT) begin
                r_cyc <= r_cyc + 64'd1;
            end
            if (w_rd && (w_idx == 3'd4)) begin
                r_cyc_hi_snap <= r_cyc[63:32];
            end
        end
    end
`endif

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            3'd1: w_rdata = r_wdog_limit;
            3'd3: w_rdata = {28'd0, r_expired, (r_state == ST_EXIT), r_state};
`ifdef SIM_EXIT_CYCLE_COUNT_EN
            3'd4: w_rdata = r_cyc[31:0];
            3'd5: w_rdata = r_cyc_hi_snap;
`endif
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign gnt_o          = req_i;
    assign rvalid_o       = r_rvalid;
    assign rdata_o        = r_rdata;
    assign exit_valid_o   = (r_state == ST_EXIT);
    assign exit_value_o   = (r_state == ST_EXIT) ? r_code : 32'd0;
    assign wdog_expired_o = r_expired;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Bench for sim_exit_ctrl: directed scenarios plus randomized bus traffic against a cycle-time model.
module tb_sim_exit_ctrl;

    localparam int          DR    = 16;
    localparam logic [31:0] WCODE = 32'hDEAD0001;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = 32'd0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        exit_valid_o;
    logic [31:0] exit_value_o;
    logic        wdog_expired_o;

    always #5 clk_i = ~clk_i;

    sim_exit_ctrl #(.DRAIN_CYCLES(DR), .WDOG_EXIT_CODE(WCODE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o),
        .wdog_expired_o(wdog_expired_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: absolute cycle numbers. m_trig = cycle of the triggering event (-1 none),
    // m_clr = cycle of the last watchdog-clearing write, m_base = first cycle after reset.
    longint      m_cyc = 0;
    longint      m_base = 0;
    longint      m_trig = -1;
    longint      m_clr = -1;
    logic [31:0] m_limit = 32'd0;
    logic [31:0] m_code = 32'd0;
    bit          m_exp = 1'b0;
    bit          e_rvalid = 1'b0;
    logic [31:0] e_rdata = 32'd0;
`ifdef SIM_EXIT_CYCLE_COUNT_EN
    logic [31:0] m_snap = 32'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phase_at(input longint c);
        if (m_trig < 0) return 0;
        if (c >= m_trig + DR + 1) return 2;
        return 1;
    endfunction

    function automatic logic [63:0] cycles_now();
        longint stop;
        stop = (phase_at(m_cyc) == 2) ? (m_trig + DR + 1) : m_cyc;
        return 64'(stop - m_base);
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        int         ph;
        logic [1:0] p2;
        ph = phase_at(m_cyc);
        p2 = ph[1:0];
        case (idx)
            1: return m_limit;
            3: return {28'd0, m_exp, (ph == 2), p2};
`ifdef SIM_EXIT_CYCLE_COUNT_EN
            4: return cycles_now()  & 64'hFFFF_FFFF;
            5: return m_snap;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        int          idx;
        int          ph;
        logic [31:0] mask;
        bit          wr, exw, clrw, expire;
        idx  = int'(addr_i[4:2]);
        ph   = phase_at(m_cyc);
        mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
        e_rvalid = req_i;
        e_rdata  = (req_i && !we_i) ? model_read(idx) : 32'd0;
`ifdef SIM_EXIT_CYCLE_COUNT_EN
        if (req_i && !we_i && idx == 4) m_snap = cycles_now() >> 32;
`endif
        wr     = req_i && we_i;
        exw    = wr && idx == 0 && be_i != 4'd0 && ph == 0;
        clrw   = wr && (idx == 1 || idx == 2);
        expire = ph == 0 && m_limit != 0 && (m_cyc - m_clr) == longint'(m_limit) && !exw && !clrw;
        if (exw) begin
            m_trig = m_cyc;
            m_code = wdata_i & mask;
        end else if (expire) begin
            m_trig = m_cyc;
            m_code = WCODE;
            m_exp  = 1'b1;
        end
        if (wr && idx == 1) m_limit = (m_limit & ~mask) | (wdata_i & mask);
        if (clrw) m_clr = m_cyc;
        m_cyc++;
    endtask

    always @(negedge clk_i) begin
        int ph;
        ph = phase_at(m_cyc);
        check("gnt", 32'(gnt_o), 32'(req_i));
        check("rvalid", 32'(rvalid_o), 32'(e_rvalid));
        if (e_rvalid) check("rdata", rdata_o, e_rdata);
        check("exit_valid", 32'(exit_valid_o), 32'(ph == 2));
        if (ph == 2) check("exit_value", exit_value_o, m_code);
        check("wdog_expired", 32'(wdog_expired_o), 32'(m_exp));
    end

    task automatic step(input logic r, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
        req_i = r; addr_i = a; we_i = w; be_i = b; wdata_i = d;
        @(posedge clk_i);
        model_edge();
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
        step(1'b1, a, 1'b1, b, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, a, 1'b0, 4'h0, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'd0, 1'b0, 4'h0, 32'd0);
    endtask

    task automatic do_reset();
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'd0; wdata_i = 32'd0;
        rst_i = 1'b1;
        m_trig = -1; m_limit = 32'd0; m_code = 32'd0; m_exp = 1'b0;
        e_rvalid = 1'b0; e_rdata = 32'd0;
`ifdef SIM_EXIT_CYCLE_COUNT_EN
        m_snap = 32'd0;
`endif
        #1;
        check("rst_exit_valid", 32'(exit_valid_o), 32'd0);
        check("rst_exit_value", exit_value_o, 32'd0);
        check("rst_wdog_expired", 32'(wdog_expired_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        @(posedge clk_i);
        #2;
        rst_i  = 1'b0;
        m_base = m_cyc;
        m_clr  = m_cyc - 1;
    endtask

    task automatic measure_exit(output int lat);
        lat = 1;
        while (!exit_valid_o && lat < 400) begin
            idle(1);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [2:0]  ridx;
        logic [31:0] a;
        int          r;

        do_reset();

        // Success exit: latency DRAIN+1 from the granted write.
        wr(32'h0, 32'h0);
        measure_exit(lat);
        check("lat_exit0", 32'(lat), 32'd17);
        check("exit0_value", exit_value_o, 32'd0);
        check("exit0_expired", 32'(wdog_expired_o), 32'd0);
        idle(3);

        // First code wins; STATUS in DRAIN.
        do_reset();
        wr(32'h0, 32'd5);
        idle(3);
        wr(32'h0, 32'd9);
        rd(32'hC);
        check("status_drain", rdata_o, 32'h1);
        idle(20);
        check("first_code_valid", 32'(exit_valid_o), 32'd1);
        check("first_code_value", exit_value_o, 32'd5);
        rd(32'hC);
        check("status_exit", rdata_o, 32'h6);

        // Watchdog expiry without kicks.
        do_reset();
        wr(32'h4, 32'd100);
        measure_exit(lat);
        check("lat_wdog", 32'(lat), 32'd117);
        check("wdog_value", exit_value_o, 32'hDEAD0001);
        check("wdog_flag", 32'(wdog_expired_o), 32'd1);

        // Periodic kicks hold off the watchdog; exit write in the expiry cycle wins.
        do_reset();
        wr(32'h4, 32'd100);
        for (int i = 0; i < 20; i++) begin
            wr(32'h8, $urandom);
            idle(49);
        end
        check("kicked_no_exit", 32'(exit_valid_o), 32'd0);
        wr(32'h8, 32'd0);
        idle(99);
        wr(32'h0, 32'd3);
        idle(20);
        check("tie_value", exit_value_o, 32'd3);
        check("tie_expired", 32'(wdog_expired_o), 32'd0);

        // Reset mid-DRAIN discards the pending exit.
        do_reset();
        wr(32'h0, 32'h1234);
        idle(5);
        do_reset();
        rd(32'hC);
        check("status_after_rst", rdata_o, 32'h0);
        wr(32'h0, 32'd7);
        idle(17);
        check("post_rst_valid", 32'(exit_valid_o), 32'd1);
        check("post_rst_value", exit_value_o, 32'd7);

        // Byte enables, unmapped offsets, empty-be exit write.
        do_reset();
        wr(32'h4, 32'hAABBCCDD, 4'b0101);
        rd(32'h4);
        check("limit_be", rdata_o, 32'h00BB00DD);
        rd(32'h18);
        check("unmapped_rd", rdata_o, 32'h0);
`ifndef SIM_EXIT_CYCLE_COUNT_EN
        rd(32'h10);
        check("cnt_lo_absent", rdata_o, 32'h0);
        rd(32'h14);
        check("cnt_hi_absent", rdata_o, 32'h0);
`endif
        wr(32'h0, 32'hFFFF, 4'b0000);
        idle(20);
        check("be0_no_exit", 32'(exit_valid_o), 32'd0);
        wr(32'h4, 32'd0);

        // Randomized traffic; the compare process checks every cycle.
        for (int rnd = 0; rnd < 25; rnd++) begin
            do_reset();
            if ($urandom_range(0, 1) == 1) wr(32'h4, $urandom_range(1, 40));
            for (int c = 0; c < 400; c++) begin
                r = $urandom_range(0, 99);
                a = $urandom;
                if (r < 2) begin
                    a[4:2] = 3'd0;
                    wr(a, $urandom, 4'($urandom_range(0, 15)));
                end else if (r < 10) begin
                    a[4:2] = 3'd1;
                    wr(a, $urandom_range(0, 40), 4'($urandom_range(0, 15)));
                end else if (r < 20) begin
                    a[4:2] = 3'd2;
                    wr(a, $urandom, 4'($urandom_range(0, 15)));
                end else if (r < 30) begin
                    ridx = 3'($urandom_range(3, 7));
                    a[4:2] = ridx;
                    wr(a, $urandom, 4'hF);
                end else if (r < 50) begin
                    ridx = 3'($urandom_range(0, 7));
                    a[4:2] = ridx;
                    rd(a);
                end else begin
                    idle(1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
